// File: rtl/hangman_pkg.sv
// hangman_pkg: letter codes, game state encoding and word-letter helpers shared by the hangman blocks
package hangman_pkg;
  typedef logic [5:0] letter_t;
  localparam letter_t LETTER_A = 6'h0A;
  localparam letter_t LETTER_Z = 6'h23;
  localparam letter_t BLANK = 6'h3F;
  localparam int NUM_LETTERS = 26;
  localparam int WORD_LEN = 4;
  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_EVAL, S_WON, S_LOST} state_t;
  function automatic letter_t letter_of(input byte c);
    return letter_t'(c - 8'd65) + LETTER_A;
  endfunction
endpackage

// File: rtl/guess_checker_if.sv
// guess_checker_if: word load, guess handshake and display/status bundle between game logic and its users
interface guess_checker_if;
  import hangman_pkg::*;
  logic start;
  letter_t letter1, letter2, letter3, letter4;
  letter_t guess;
  logic guess_valid, guess_ready;
  logic [3:0] revealed;
  letter_t disp1, disp2, disp3, disp4;
  logic [2:0] lives;
  logic hit, miss, repeat_guess, invalid, game_won, game_lost;
  modport master(output start, letter1, letter2, letter3, letter4, guess, guess_valid,
                 input guess_ready, revealed, disp1, disp2, disp3, disp4, lives,
                 hit, miss, repeat_guess, invalid, game_won, game_lost);
  modport slave(input start, letter1, letter2, letter3, letter4, guess, guess_valid,
                output guess_ready, revealed, disp1, disp2, disp3, disp4, lives,
                hit, miss, repeat_guess, invalid, game_won, game_lost);
endinterface

// File: rtl/guess_checker_letter_match.sv
// letter_match: per-position match mask of a guess against the four word letters, plus range flag
module letter_match
  import hangman_pkg::*;
(
  input  letter_t       i_guess,
  input  letter_t [3:0] i_word,
  output logic    [3:0] o_mask,
  output logic          o_any,
  output logic          o_in_range
);
  assign o_in_range = i_guess >= LETTER_A && i_guess <= LETTER_Z;
  for (genvar k = 0; k < WORD_LEN; k++) begin : g_pos
    assign o_mask[k] = o_in_range && i_guess == i_word[k];
  end
  assign o_any = |o_mask;
endmodule

// File: rtl/guess_checker.sv
// guess_checker: hangman game logic; latches a word on start, evaluates one guess per two cycles,
// tracks revealed positions, used letters and lives, and drives display codes and win/lose status.
module guess_checker
  import hangman_pkg::*;
#(
  parameter int MAX_LIVES = 6
) (
  input logic            i_clock,
  input logic            i_resetn,
  guess_checker_if.slave io_bus
);
  state_t r_state, w_next;
  letter_t [3:0] r_word;
  letter_t r_guess;
  logic [3:0] r_revealed;
  logic [NUM_LETTERS-1:0] r_used;
  logic [2:0] r_lives;
  logic r_hit, r_miss, r_repeat, r_invalid, r_won, r_lost;
  logic [3:0] w_mask, w_rev_next;
  logic [NUM_LETTERS-1:0] w_bit;
  logic w_any, w_in_range, w_used, w_eval, w_hit, w_miss, w_repeat, w_invalid, w_win, w_lose;
  letter_match u_match (
    .i_guess   (r_guess),
    .i_word    (r_word),
    .o_mask    (w_mask),
    .o_any     (w_any),
    .o_in_range(w_in_range)
  );
  // out-of-range guesses shift the bit off the end, so w_used is only trusted when in range
  assign w_bit = NUM_LETTERS'(1) << (r_guess - LETTER_A);
  assign w_used = |(r_used & w_bit);
  assign w_eval = r_state == S_EVAL && !io_bus.start;
  assign w_invalid = w_eval && !w_in_range;
  assign w_repeat = w_eval && w_in_range && w_used;
  assign w_hit = w_eval && w_in_range && !w_used && w_any;
  assign w_miss = w_eval && w_in_range && !w_used && !w_any;
  assign w_rev_next = r_revealed | w_mask;
  assign w_win = w_hit && &w_rev_next;
  assign w_lose = w_miss && r_lives == 3'd1;
  always_comb begin
    w_next = r_state;
    if (io_bus.start) w_next = S_PLAY;
    else if (r_state == S_PLAY && io_bus.guess_valid) w_next = S_EVAL;
    else if (r_state == S_EVAL) w_next = w_win ? S_WON : w_lose ? S_LOST : S_PLAY;
  end
  always_ff @(posedge i_clock) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_word <= '0;
      r_guess <= '0;
      r_revealed <= '0;
      r_used <= '0;
      r_lives <= '0;
      r_hit <= 1'b0;
      r_miss <= 1'b0;
      r_repeat <= 1'b0;
      r_invalid <= 1'b0;
      r_won <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hit <= w_hit;
      r_miss <= w_miss;
      r_repeat <= w_repeat;
      r_invalid <= w_invalid;
      if (io_bus.start) begin
        r_word <= {io_bus.letter4, io_bus.letter3, io_bus.letter2, io_bus.letter1};
        r_revealed <= '0;
        r_used <= '0;
        r_lives <= 3'(MAX_LIVES);
        r_won <= 1'b0;
        r_lost <= 1'b0;
      end else begin
        if (r_state == S_PLAY && io_bus.guess_valid) r_guess <= io_bus.guess;
        if (w_hit || w_miss) r_used <= r_used | w_bit;
        if (w_hit) r_revealed <= w_rev_next;
        if (w_miss) r_lives <= r_lives - 3'd1;
        r_won <= r_won | w_win;
        r_lost <= r_lost | w_lose;
      end
    end
  end
  assign io_bus.guess_ready = r_state == S_PLAY;
  assign io_bus.revealed = r_revealed;
  assign io_bus.lives = r_lives;
  assign io_bus.hit = r_hit;
  assign io_bus.miss = r_miss;
  assign io_bus.repeat_guess = r_repeat;
  assign io_bus.invalid = r_invalid;
  assign io_bus.game_won = r_won;
  assign io_bus.game_lost = r_lost;
  assign io_bus.disp1 = r_revealed[0] || r_won || r_lost ? r_word[0] : BLANK;
  assign io_bus.disp2 = r_revealed[1] || r_won || r_lost ? r_word[1] : BLANK;
  assign io_bus.disp3 = r_revealed[2] || r_won || r_lost ? r_word[2] : BLANK;
  assign io_bus.disp4 = r_revealed[3] || r_won || r_lost ? r_word[3] : BLANK;
endmodule

// File: tb/tb_guess_checker.sv
// tb_guess_checker: directed game scenarios plus random play, checked every cycle against a game-rules model
module tb_guess_checker;
  import hangman_pkg::*;
  localparam int ML = 6;
  logic clk = 0, rstn = 0;
  always #5 clk = ~clk;
  guess_checker_if bus();
  guess_checker #(.MAX_LIVES(ML)) dut (.i_clock(clk), .i_resetn(rstn), .io_bus(bus.slave));
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // game-rules model: which letters were guessed, lives left, one pending guess
  bit m_en, m_act, m_pend, m_won, m_lost;
  int m_word[4];
  bit m_used[26];
  int m_lives, m_pg, m_pulse;
  function automatic bit in_word(input int g);
    for (int i = 0; i < 4; i++) if (m_word[i] == g) return 1;
    return 0;
  endfunction
  function automatic logic [3:0] exp_rev();
    logic [3:0] r = '0;
    for (int i = 0; i < 4; i++) r[i] = m_word[i] >= 10 && m_word[i] <= 35 && m_used[m_word[i] - 10];
    return r;
  endfunction
  function automatic logic [23:0] exp_disp();
    logic [23:0] d;
    logic [3:0] r = exp_rev();
    for (int i = 0; i < 4; i++) d[i*6 +: 6] = (r[i] || m_won || m_lost) ? 6'(m_word[i]) : 6'h3F;
    return d;
  endfunction
  function automatic bit exp_ready();
    return m_act && !m_pend && !m_won && !m_lost;
  endfunction
  always @(posedge clk) begin
    m_en = 1;
    m_pulse = 0;
    if (!rstn) begin
      {m_act, m_pend, m_won, m_lost} = '0;
      m_lives = 0;
      foreach (m_used[i]) m_used[i] = 0;
      foreach (m_word[i]) m_word[i] = 0;
    end else if (bus.start) begin
      {m_act, m_pend, m_won, m_lost} = 4'b1000;
      m_lives = ML;
      foreach (m_used[i]) m_used[i] = 0;
      m_word = '{int'(bus.letter1), int'(bus.letter2), int'(bus.letter3), int'(bus.letter4)};
    end else if (m_pend) begin
      m_pend = 0;
      if (m_pg < 10 || m_pg > 35) m_pulse = 1;
      else if (m_used[m_pg - 10]) m_pulse = 2;
      else begin
        m_used[m_pg - 10] = 1;
        if (in_word(m_pg)) begin
          m_pulse = 8;
          if (exp_rev() == 4'hF) m_won = 1;
        end else begin
          m_pulse = 4;
          m_lives--;
          if (m_lives == 0) m_lost = 1;
        end
      end
    end else if (exp_ready() && bus.guess_valid) begin
      m_pend = 1;
      m_pg = int'(bus.guess);
    end
  end
  always @(negedge clk) if (m_en) begin
    chk("ready", bus.guess_ready, exp_ready());
    chk("revealed", bus.revealed, exp_rev());
    chk("lives", bus.lives, m_lives);
    chk("pulses", {bus.hit, bus.miss, bus.repeat_guess, bus.invalid}, m_pulse);
    chk("flags", {bus.game_won, bus.game_lost}, {m_won, m_lost});
    chk("disp", {bus.disp4, bus.disp3, bus.disp2, bus.disp1}, exp_disp());
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic new_game(input logic [5:0] a, b, c, d);
    {bus.letter1, bus.letter2, bus.letter3, bus.letter4} = {a, b, c, d};
    bus.start = 1;
    tick();
    bus.start = 0;
  endtask
  task automatic do_guess(input logic [5:0] g);
    int n = 0;
    while (!bus.guess_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.guess_ready) chk("ready_timeout", 0, 1);
    bus.guess = g;
    bus.guess_valid = 1;
    tick();
    bus.guess_valid = 0;
    tick();
  endtask
  initial begin
    bus.start = 0;
    bus.guess_valid = 0;
    bus.guess = 0;
    {bus.letter1, bus.letter2, bus.letter3, bus.letter4} = '0;
    tick();
    tick();
    chk("rst_ready", bus.guess_ready, 0);
    chk("rst_lives", bus.lives, 0);
    chk("rst_disp", {bus.disp4, bus.disp3, bus.disp2, bus.disp1}, {4{6'h3F}});
    rstn = 1;
    tick();
    new_game(6'h11, 6'h0E, 6'h0A, 6'h0D);
    chk("start_ready", bus.guess_ready, 1);
    do_guess(6'h0A);
    chk("head_hit", bus.hit, 1);
    chk("head_rev", bus.revealed, 4'b0100);
    chk("head_disp", {bus.disp4, bus.disp3, bus.disp2, bus.disp1}, {6'h3F, 6'h0A, 6'h3F, 6'h3F});
    chk("head_lives", bus.lives, 6);
    new_game(6'h15, 6'h12, 6'h0F, 6'h0E);
    for (int k = 0; k < 6; k++) begin
      do_guess(6'(6'h23 - k));
      chk("life_miss", bus.miss, 1);
      chk("life_lives", bus.lives, 5 - k);
    end
    chk("life_lost", bus.game_lost, 1);
    chk("life_ready", bus.guess_ready, 0);
    chk("life_disp", {bus.disp4, bus.disp3, bus.disp2, bus.disp1}, {6'h0E, 6'h0F, 6'h12, 6'h15});
    new_game(6'h0D, 6'h0A, 6'h1B, 6'h17);
    do_guess(6'h0A);
    chk("darn_hit", bus.hit, 1);
    do_guess(6'h0A);
    chk("darn_rep", bus.repeat_guess, 1);
    chk("darn_lives", bus.lives, 6);
    chk("darn_rev", bus.revealed, 4'b0010);
    new_game(6'h1C, 6'h1D, 6'h0A, 6'h22);
    do_guess(6'h1C);
    do_guess(6'h1D);
    do_guess(6'h0A);
    do_guess(6'h22);
    chk("stay_won", bus.game_won, 1);
    chk("stay_rev", bus.revealed, 4'hF);
    bus.guess = 6'h0B;
    bus.guess_valid = 1;
    repeat (4) tick();
    bus.guess_valid = 0;
    chk("stay_hold", {bus.game_won, bus.revealed, bus.lives}, {1'b1, 4'hF, 3'd6});
    new_game(6'h11, 6'h0E, 6'h0A, 6'h0D);
    do_guess(6'h05);
    chk("inv_lo", bus.invalid, 1);
    do_guess(6'h3F);
    chk("inv_hi", bus.invalid, 1);
    chk("inv_state", {bus.revealed, bus.lives}, {4'b0, 3'd6});
    new_game(6'h0D, 6'h0A, 6'h1B, 6'h17);
    bus.start = 1;
    bus.guess = 6'h0A;
    bus.guess_valid = 1;
    tick();
    bus.start = 0;
    bus.guess_valid = 0;
    chk("prio_ready", bus.guess_ready, 1);
    tick();
    chk("prio_nopulse", {bus.hit, bus.miss, bus.repeat_guess, bus.invalid, bus.revealed}, 0);
    bus.guess = 6'h0D;
    bus.guess_valid = 1;
    tick();
    bus.guess_valid = 0;
    rstn = 0;
    tick();
    chk("rst_mid", {bus.guess_ready, bus.lives, bus.revealed, bus.hit, bus.game_won, bus.game_lost}, 0);
    chk("rst_mid_disp", {bus.disp4, bus.disp3, bus.disp2, bus.disp1}, {4{6'h3F}});
    rstn = 1;
    tick();
    chk("rst_after", {bus.hit, bus.miss, bus.repeat_guess, bus.invalid}, 0);
    for (int c = 0; c < 1500; c++) begin
      rstn = $urandom_range(0, 299) != 0;
      bus.start = $urandom_range(0, 24) == 0;
      bus.letter1 = 6'($urandom_range(10, 35));
      bus.letter2 = 6'($urandom_range(10, 35));
      bus.letter3 = 6'($urandom_range(10, 35));
      bus.letter4 = 6'($urandom_range(10, 35));
      bus.guess = $urandom_range(0, 3) == 0 ? 6'($urandom_range(0, 63)) : 6'($urandom_range(10, 35));
      bus.guess_valid = $urandom_range(0, 1) == 1;
      tick();
    end
    rstn = 1;
    bus.start = 0;
    bus.guess_valid = 0;
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
